ncl_fullword_capture: RTL and testbench

Clocked receiver for dual-rail NCL words, placed directly downstream of the 32-bit full-word-completeness counter. It consumes the counter's dual-rail sum and carry-out wavefronts and returns the word completeness signal that sequences the counter's DATA/NULL cycle. Each complete DATA wavefront is decoded to single-rail binary and pushed into a small show-ahead FIFO with a valid/ready output. This block is the bridge between the NCL counter and synchronous consumers.

---
 rtl/ncl_fullword_capture.sv | 139 +++++++++++++
 tb/tb_ncl_fullword_capture.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ncl_fullword_capture.sv
// Synchronizes dual-rail NCL sum/carry wavefronts, returns completeness upstream, and queues decoded words in a show-ahead FIFO.
// Optional illegal-codeword (11 pair) detection is built when NCL_ILLEGAL_CHECK_EN is defined.
module ncl_fullword_capture #(
   parameter int WIDTH       = 32,
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                         clk,
   input  logic                         init,
   input  logic [2*WIDTH-1:0]           sum_dr,
   input  logic [1:0]                   carry_dr,
   output logic                         comp,
   output logic [WIDTH-1:0]             out_data,
   output logic                         out_carry,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic                         illegal
);

   localparam int RAILS = 2*WIDTH + 2;
   localparam int PAIRS = WIDTH + 1;
   localparam int LW    = $clog2(DEPTH+1);
   localparam int PW    = $clog2(DEPTH);

   typedef enum logic {WAIT_DATA, WAIT_NULL} state_t;

   state_t               state_q, state_d;
   logic [RAILS-1:0]     sync_q [SYNC_STAGES];
   logic [RAILS-1:0]     sync_d [SYNC_STAGES];
   logic [WIDTH:0]       mem_q  [DEPTH];
   logic [WIDTH:0]       mem_d  [DEPTH];
   logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]        level_q, level_d;

   logic [RAILS-1:0]     rails;
   logic [WIDTH:0]       word;
   logic                 all_data, all_null, full, push, pop;

   always_comb begin
      sync_d[0] = {carry_dr, sum_dr};
      for (int i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
   end

   assign rails = sync_q[SYNC_STAGES-1];

   // Pair WIDTH is the carry, so the decoded word is {carry, sum}.
   always_comb begin
      all_data = 1'b1;
      word     = '0;
      for (int p = 0; p < PAIRS; p++) begin
         if (rails[2*p] == rails[2*p+1]) all_data = 1'b0;
         word[p] = rails[2*p+1];
      end
      all_null = (rails == '0);
   end

   assign full = (level_q == LW'(DEPTH));
   assign pop  = out_valid && out_ready;

   always_comb begin
      state_d = state_q;
      push    = 1'b0;
      case (state_q)
         WAIT_DATA: begin
            if (all_data && !full) begin
               push    = 1'b1;
               state_d = WAIT_NULL;
            end
         end
         WAIT_NULL: begin
            if (all_null) state_d = WAIT_DATA;
         end
         default: state_d = WAIT_DATA;
      endcase
   end

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q + LW'(push) - LW'(pop);
      if (push) begin
         mem_d[wr_ptr_q] = word;
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (init) begin
         state_q  <= WAIT_DATA;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      end
   end

   assign comp      = (state_q == WAIT_NULL);
   assign out_valid = (level_q != '0);
   assign level     = level_q;
   assign out_data  = mem_q[rd_ptr_q][WIDTH-1:0];
   assign out_carry = mem_q[rd_ptr_q][WIDTH];

`ifdef NCL_ILLEGAL_CHECK_EN
   logic illegal_q, illegal_d;

   // Sticky: any synchronized 11 pair latches the flag until init.
   always_comb begin
      illegal_d = illegal_q;
      for (int p = 0; p < PAIRS; p++) begin
         if (rails[2*p] && rails[2*p+1]) illegal_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (init) illegal_q <= 1'b0;
      else      illegal_q <= illegal_d;
   end

   assign illegal = illegal_q;
`else
   assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_ncl_fullword_capture.sv
// Directed self-checking bench for ncl_fullword_capture: vector table plus hand-written
// backpressure, skew, init and illegal-codeword sequences.
module tb_ncl_fullword_capture;

   localparam int WIDTH = 32;
   localparam int DEPTH = 4;
   localparam int SYNC  = 2;

`ifdef NCL_ILLEGAL_CHECK_EN
   localparam logic EXP_ILLEGAL = 1'b1;
`else
   localparam logic EXP_ILLEGAL = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              init;
   logic [2*WIDTH-1:0] sum_dr;
   logic [1:0]        carry_dr;
   logic              comp;
   logic [WIDTH-1:0]  out_data;
   logic              out_carry;
   logic              out_valid;
   logic              out_ready;
   logic [2:0]        level;
   logic              illegal;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [31:0] sum;
      logic        carry;
      logic [31:0] exp_data;
      logic        exp_carry;
   } vec_t;

   vec_t vecs[5];

   ncl_fullword_capture #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
      .clk(clk), .init(init), .sum_dr(sum_dr), .carry_dr(carry_dr), .comp(comp),
      .out_data(out_data), .out_carry(out_carry), .out_valid(out_valid),
      .out_ready(out_ready), .level(level), .illegal(illegal)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic [63:0] toDualRail(input logic [31:0] v);
      logic [63:0] r;
      for (int k = 0; k < 32; k++) begin
         r[2*k+1] = v[k];
         r[2*k]   = ~v[k];
      end
      return r;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [31:0] sum, input logic carry);
      sum_dr   = toDualRail(sum);
      carry_dr = {carry, ~carry};
   endtask

   task automatic applyNull();
      sum_dr   = '0;
      carry_dr = 2'b00;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic pulseInit();
      init = 1'b1;
      tick(1);
      init = 1'b0;
   endtask

   initial begin
      vecs[0] = '{32'h0000_0005, 1'b0, 32'h0000_0005, 1'b0};
      vecs[1] = '{32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};
      vecs[2] = '{32'hA5A5_A5A5, 1'b0, 32'hA5A5_A5A5, 1'b0};
      vecs[3] = '{32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1};
      vecs[4] = '{32'h8000_0001, 1'b0, 32'h8000_0001, 1'b0};

      init      = 1'b1;
      out_ready = 1'b0;
      applyNull();
      tick(2);
      checkOutput("reset comp", comp, 0);
      checkOutput("reset out_valid", out_valid, 0);
      checkOutput("reset level", level, 0);
      checkOutput("reset out_data", out_data, 0);
      checkOutput("reset out_carry", out_carry, 0);
      checkOutput("reset illegal", illegal, 0);
      init = 1'b0;
      tick(3);

      // Table: capture latency, decode, pop, NULL return latency.
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(vecs[i].sum, vecs[i].carry);
         tick(2);
         checkOutput($sformatf("vec%0d comp early", i), comp, 0);
         checkOutput($sformatf("vec%0d valid early", i), out_valid, 0);
         tick(1);
         checkOutput($sformatf("vec%0d comp", i), comp, 1);
         checkOutput($sformatf("vec%0d valid", i), out_valid, 1);
         checkOutput($sformatf("vec%0d data", i), out_data, vecs[i].exp_data);
         checkOutput($sformatf("vec%0d carry", i), out_carry, vecs[i].exp_carry);
         checkOutput($sformatf("vec%0d level", i), level, 1);
         applyNull();
         tick(1);
         checkOutput($sformatf("vec%0d level after pop", i), level, 0);
         tick(1);
         checkOutput($sformatf("vec%0d comp held", i), comp, 1);
         tick(1);
         checkOutput($sformatf("vec%0d comp fall", i), comp, 0);
      end

      // Skewed wavefront: lower 16 pairs first, rest five cycles later.
      out_ready = 1'b0;
      sum_dr    = '0;
      sum_dr[31:0] = toDualRail(32'h0000_1234) & 64'h0000_0000_FFFF_FFFF;
      for (int c = 0; c < 5; c++) begin
         tick(1);
         checkOutput($sformatf("skew comp c%0d", c), comp, 0);
         checkOutput($sformatf("skew level c%0d", c), level, 0);
      end
      applyStimulus(32'h0000_1234, 1'b0);
      tick(2);
      checkOutput("skew comp before", comp, 0);
      tick(1);
      checkOutput("skew comp", comp, 1);
      checkOutput("skew data", out_data, 32'h0000_1234);
      checkOutput("skew level", level, 1);
      applyNull();
      out_ready = 1'b1;
      tick(1);
      out_ready = 1'b0;
      tick(2);
      checkOutput("skew null comp", comp, 0);
      checkOutput("skew level drained", level, 0);

      // Backpressure: four words fill the FIFO, the fifth stalls.
      for (int w = 1; w <= 4; w++) begin
         applyStimulus(w, 1'b0);
         tick(3);
         checkOutput($sformatf("bp word%0d comp", w), comp, 1);
         checkOutput($sformatf("bp word%0d level", w), level, w);
         applyNull();
         tick(3);
         checkOutput($sformatf("bp word%0d null", w), comp, 0);
      end
      applyStimulus(32'd5, 1'b0);
      tick(6);
      checkOutput("bp stall comp", comp, 0);
      checkOutput("bp stall level", level, 4);
      checkOutput("bp head", out_data, 1);
      out_ready = 1'b1;
      tick(1);
      out_ready = 1'b0;
      checkOutput("bp pop level", level, 3);
      checkOutput("bp pop comp", comp, 0);
      tick(1);
      checkOutput("bp late push level", level, 4);
      checkOutput("bp late push comp", comp, 1);
      applyNull();
      out_ready = 1'b1;
      for (int w = 2; w <= 5; w++) begin
         checkOutput($sformatf("bp drain head%0d", w), out_data, w);
         tick(1);
      end
      out_ready = 1'b0;
      checkOutput("bp drained level", level, 0);
      checkOutput("bp drained valid", out_valid, 0);
      tick(2);
      checkOutput("bp null comp", comp, 0);

      // Init during WAIT_NULL with two words queued.
      applyStimulus(32'h0000_00AA, 1'b0);
      tick(3);
      applyNull();
      tick(3);
      applyStimulus(32'h0000_00BB, 1'b1);
      tick(3);
      checkOutput("init pre comp", comp, 1);
      checkOutput("init pre level", level, 2);
      pulseInit();
      checkOutput("init comp", comp, 0);
      checkOutput("init valid", out_valid, 0);
      checkOutput("init level", level, 0);
      checkOutput("init data", out_data, 0);
      tick(2);
      checkOutput("init recapture early", comp, 0);
      tick(1);
      checkOutput("init recapture comp", comp, 1);
      checkOutput("init recapture level", level, 1);
      checkOutput("init recapture data", out_data, 32'h0000_00BB);
      checkOutput("init recapture carry", out_carry, 1);
      applyNull();
      out_ready = 1'b1;
      tick(3);
      out_ready = 1'b0;
      checkOutput("init null comp", comp, 0);
      checkOutput("init drained", level, 0);

      // Illegal codeword on pair 7: never captured, flag sticky when enabled.
      applyStimulus(32'h1234_5678, 1'b0);
      sum_dr[15:14] = 2'b11;
      tick(2);
      checkOutput("illegal early", illegal, 0);
      tick(1);
      checkOutput("illegal set", illegal, EXP_ILLEGAL);
      checkOutput("illegal comp", comp, 0);
      tick(3);
      checkOutput("illegal no push", level, 0);
      checkOutput("illegal held comp", comp, 0);
      applyNull();
      tick(4);
      checkOutput("illegal sticky", illegal, EXP_ILLEGAL);
      pulseInit();
      checkOutput("illegal cleared", illegal, 0);
      tick(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
